// File: rtl/sargantana_icache_pkg.sv
// rtl/sargantana_icache_pkg.sv - shared types and sizing helpers for the icache refill path
//
// Purpose: state encoding for the iFill controller, beat/counter sizing
// helpers and the default line-buffer type.
// Ports: none (package).

package sargantana_icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DRAIN,
    ST_RESP
  } ifill_ctrl_state_t;

  localparam int unsigned LINE_BITS_DEF = 512;
  localparam int unsigned BUS_BITS_DEF  = 128;

  // Number of bus beats that make up one cache line.
  function automatic int unsigned beats_f(input int unsigned line_bits,
                                          input int unsigned bus_bits);
    return line_bits / bus_bits;
  endfunction

  // Beat counter width; a single-beat line still needs a 1-bit counter.
  function automatic int unsigned cnt_w_f(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned BEATS      = beats_f(LINE_BITS_DEF, BUS_BITS_DEF);
  localparam int unsigned BEAT_CNT_W = cnt_w_f(BEATS);

  typedef logic [LINE_BITS_DEF-1:0] line_t;

endpackage

// File: rtl/sargantana_icache_line_buf.sv
// rtl/sargantana_icache_line_buf.sv - beat-indexed cache line assembly register
//
// Purpose: holds one cache line; each write places one bus beat at slice idx_i.
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   we_i           write the beat this cycle
//   idx_i          beat slot to write
//   beat_i         beat data
//   line_o         assembled line (holds until overwritten)

module sargantana_icache_line_buf
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned LINE_BITS = LINE_BITS_DEF,
  parameter int unsigned BUS_BITS  = BUS_BITS_DEF,
  parameter int unsigned CNT_W     = BEAT_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 we_i,
  input  logic [CNT_W-1:0]     idx_i,
  input  logic [BUS_BITS-1:0]  beat_i,
  output logic [LINE_BITS-1:0] line_o
);

  logic [LINE_BITS-1:0] line_d;
  logic [LINE_BITS-1:0] line_q;

  always_comb begin
    line_d = line_q;
    if (we_i) begin
      line_d[int'(idx_i)*BUS_BITS +: BUS_BITS] = beat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/sargantana_icache_ifill_ctrl.sv
// rtl/sargantana_icache_ifill_ctrl.sv - icache line refill and invalidation forwarding controller
//
// Purpose: takes one icache miss at a time, issues a line-aligned read to
// memory, assembles the returned beats into a line and returns it as a single
// response. Forwards external invalidations while idle. flush_i abandons a
// fill but always lets an accepted memory read finish its beats.
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   flush_i                        abandon fill in progress
//   ifill_req_*                    miss request from the icache
//   ifill_resp_*                   line response and invalidate pulse to the icache
//   mem_req_* / mem_resp_*         line read request and beat return from memory
//   inv_valid_i/inv_paddr_i/inv_ready_o  external invalidation handshake

module sargantana_icache_ifill_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_SIZE = 40,
  parameter int unsigned LINE_BITS  = LINE_BITS_DEF,
  parameter int unsigned BUS_BITS   = BUS_BITS_DEF,
  parameter int unsigned WAY_BITS   = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  ifill_req_valid_i,
  input  logic [WAY_BITS-1:0]   ifill_req_way_i,
  input  logic [PADDR_SIZE-1:0] ifill_req_paddr_i,
  output logic                  ifill_resp_valid_o,
  output logic                  ifill_resp_ack_o,
  output logic [LINE_BITS-1:0]  ifill_resp_data_o,
  output logic                  ifill_resp_inv_valid_o,
  output logic [PADDR_SIZE-1:0] ifill_resp_inv_paddr_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PADDR_SIZE-1:0] mem_req_paddr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BUS_BITS-1:0]   mem_resp_data_i,
  input  logic                  inv_valid_i,
  input  logic [PADDR_SIZE-1:0] inv_paddr_i,
  output logic                  inv_ready_o
);

  localparam int unsigned NBEATS   = beats_f(LINE_BITS, BUS_BITS);
  localparam int unsigned CNT_W    = cnt_w_f(NBEATS);
  localparam int unsigned OFF_BITS = $clog2(LINE_BITS / 8);

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [PADDR_SIZE-1:0] LINE_MASK =
    ~((PADDR_SIZE'(1) << OFF_BITS) - PADDR_SIZE'(1));

  ifill_ctrl_state_t     state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [PADDR_SIZE-1:0] paddr_d, paddr_q;
  logic [WAY_BITS-1:0]   unused_way_d, unused_way_q;
  logic                  inv_valid_d, inv_valid_q;
  logic [PADDR_SIZE-1:0] inv_paddr_d, inv_paddr_q;
  logic                  buf_we;
  logic                  idle;

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    paddr_d      = paddr_q;
    unused_way_d = unused_way_q;
    inv_valid_d  = 1'b0;
    inv_paddr_d  = inv_paddr_q;
    buf_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Invalidation wins over a miss presented in the same cycle.
        if (inv_valid_i) begin
          inv_valid_d = 1'b1;
          inv_paddr_d = inv_paddr_i;
        end else if (ifill_req_valid_i && !flush_i) begin
          paddr_d      = ifill_req_paddr_i & LINE_MASK;
          unused_way_d = ifill_req_way_i;
          state_d      = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_req_ready_i) begin
          cnt_d = '0;
          // Once memory has taken the read its beats must be absorbed.
          state_d = flush_i ? ST_DRAIN : ST_FILL;
        end else if (flush_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (mem_resp_valid_i) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            // A flush on the final beat leaves nothing to drain.
            state_d = flush_i ? ST_IDLE : ST_RESP;
          end else if (flush_i) begin
            state_d = ST_DRAIN;
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (mem_resp_valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      paddr_q      <= '0;
      unused_way_q <= '0;
      inv_valid_q  <= 1'b0;
      inv_paddr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      paddr_q      <= paddr_d;
      unused_way_q <= unused_way_d;
      inv_valid_q  <= inv_valid_d;
      inv_paddr_q  <= inv_paddr_d;
    end
  end

  sargantana_icache_line_buf #(
    .LINE_BITS (LINE_BITS),
    .BUS_BITS  (BUS_BITS),
    .CNT_W     (CNT_W)
  ) u_line_buf (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .we_i   (buf_we),
    .idx_i  (cnt_q),
    .beat_i (mem_resp_data_i),
    .line_o (ifill_resp_data_o)
  );

  assign inv_ready_o            = idle && inv_valid_i;
  assign mem_req_valid_o        = (state_q == ST_REQ);
  assign mem_req_paddr_o        = paddr_q;
  // A flush landing on the response cycle cancels the response.
  assign ifill_resp_valid_o     = (state_q == ST_RESP) && !flush_i;
  assign ifill_resp_ack_o       = (state_q == ST_RESP) && !flush_i;
  assign ifill_resp_inv_valid_o = inv_valid_q;
  assign ifill_resp_inv_paddr_o = inv_paddr_q;

endmodule

// File: tb/tb_sargantana_icache_ifill_ctrl.sv
// tb/tb_sargantana_icache_ifill_ctrl.sv - directed self-checking bench for the iFill controller

module tb_sargantana_icache_ifill_ctrl;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         flush_i;
  logic         ifill_req_valid_i;
  logic [1:0]   ifill_req_way_i;
  logic [39:0]  ifill_req_paddr_i;
  logic         ifill_resp_valid_o;
  logic         ifill_resp_ack_o;
  logic [511:0] ifill_resp_data_o;
  logic         ifill_resp_inv_valid_o;
  logic [39:0]  ifill_resp_inv_paddr_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [39:0]  mem_req_paddr_o;
  logic         mem_resp_valid_i;
  logic [127:0] mem_resp_data_i;
  logic         inv_valid_i;
  logic [39:0]  inv_paddr_i;
  logic         inv_ready_o;

  int checks = 0;
  int errors = 0;

  logic [127:0] beat_tbl [4];
  sargantana_icache_pkg::line_t exp_line;

  always #5 clk_i = ~clk_i;

  sargantana_icache_ifill_ctrl dut (
    .clk_i                  (clk_i),
    .rstn_i                 (rstn_i),
    .flush_i                (flush_i),
    .ifill_req_valid_i      (ifill_req_valid_i),
    .ifill_req_way_i        (ifill_req_way_i),
    .ifill_req_paddr_i      (ifill_req_paddr_i),
    .ifill_resp_valid_o     (ifill_resp_valid_o),
    .ifill_resp_ack_o       (ifill_resp_ack_o),
    .ifill_resp_data_o      (ifill_resp_data_o),
    .ifill_resp_inv_valid_o (ifill_resp_inv_valid_o),
    .ifill_resp_inv_paddr_o (ifill_resp_inv_paddr_o),
    .mem_req_valid_o        (mem_req_valid_o),
    .mem_req_ready_i        (mem_req_ready_i),
    .mem_req_paddr_o        (mem_req_paddr_o),
    .mem_resp_valid_i       (mem_resp_valid_i),
    .mem_resp_data_i        (mem_resp_data_i),
    .inv_valid_i            (inv_valid_i),
    .inv_paddr_i            (inv_paddr_i),
    .inv_ready_o            (inv_ready_o)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Entered while the DUT is in REQ.
  task automatic req_phase(input logic [39:0] exp_addr, input int ready_delay);
    #1;
    chk("req_valid", mem_req_valid_o, 1);
    chk("req_paddr", mem_req_paddr_o, exp_addr);
    chk("req_inv_ready", inv_ready_o, 0);
    for (int i = 0; i < ready_delay; i++) begin
      mem_req_ready_i = 1'b0;
      tick();
      #1;
      chk("req_hold", mem_req_valid_o, 1);
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
  endtask

  // Entered in the first FILL cycle; leaves in IDLE after the response.
  task automatic fill_phase(input int gap);
    for (int i = 0; i < sargantana_icache_pkg::BEATS; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          mem_resp_valid_i = 1'b0;
          #1;
          chk("fill_no_resp", ifill_resp_valid_o, 0);
          chk("fill_inv_ready", inv_ready_o, 0);
          tick();
        end
      end
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = beat_tbl[i];
      #1;
      chk("fill_no_resp", ifill_resp_valid_o, 0);
      chk("fill_inv_ready", inv_ready_o, 0);
      tick();
    end
    mem_resp_valid_i  = 1'b0;
    ifill_req_valid_i = 1'b0;
    exp_line = {beat_tbl[3], beat_tbl[2], beat_tbl[1], beat_tbl[0]};
    #1;
    chk("resp_valid", ifill_resp_valid_o, 1);
    chk("resp_ack", ifill_resp_ack_o, 1);
    chk("resp_data", ifill_resp_data_o, exp_line);
    chk("resp_inv_ready", inv_ready_o, 0);
    tick();
    #1;
    chk("resp_one_cycle_valid", ifill_resp_valid_o, 0);
    chk("resp_one_cycle_ack", ifill_resp_ack_o, 0);
    chk("resp_data_hold", ifill_resp_data_o, exp_line);
  endtask

  task automatic run_fill(input logic [39:0] addr, input logic [39:0] exp_addr,
                          input int ready_delay, input int gap);
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = addr;
    ifill_req_way_i   = 2'd1;
    #1;
    chk("idle_no_req", mem_req_valid_o, 0);
    tick();
    req_phase(exp_addr, ready_delay);
    fill_phase(gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i            = 1'b0;
    flush_i           = 1'b0;
    ifill_req_valid_i = 1'b0;
    ifill_req_way_i   = 2'd0;
    ifill_req_paddr_i = '0;
    mem_req_ready_i   = 1'b0;
    mem_resp_valid_i  = 1'b0;
    mem_resp_data_i   = '0;
    inv_valid_i       = 1'b0;
    inv_paddr_i       = '0;

    // Reset state
    #12;
    chk("rst_mem_req_valid", mem_req_valid_o, 0);
    chk("rst_resp_valid", ifill_resp_valid_o, 0);
    chk("rst_resp_ack", ifill_resp_ack_o, 0);
    chk("rst_inv_valid", ifill_resp_inv_valid_o, 0);
    chk("rst_inv_paddr", ifill_resp_inv_paddr_o, 0);
    chk("rst_mem_paddr", mem_req_paddr_o, 0);
    chk("rst_data", ifill_resp_data_o, 0);
    chk("rst_inv_ready", inv_ready_o, 0);
    rstn_i = 1'b1;
    tick();

    // Basic fill, response at t+6
    beat_tbl[0] = {4{32'hAAAA_0001}};
    beat_tbl[1] = {4{32'hBBBB_0002}};
    beat_tbl[2] = {4{32'hCCCC_0003}};
    beat_tbl[3] = {4{32'hDDDD_0004}};
    run_fill(40'h80_0000_0044, 40'h80_0000_0040, 0, 0);

    // Request backpressure and beat gaps
    beat_tbl[0] = {4{32'h1111_1111}};
    beat_tbl[1] = {4{32'h2222_2222}};
    beat_tbl[2] = {4{32'h3333_3333}};
    beat_tbl[3] = {4{32'h4444_4444}};
    run_fill(40'h80_0000_1234, 40'h80_0000_1200, 5, 2);

    // Flush in REQ before ready
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h80_0000_2000;
    tick();
    flush_i           = 1'b1;
    ifill_req_valid_i = 1'b0;
    #1;
    chk("flush_req_valid_before", mem_req_valid_o, 1);
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_req_dropped", mem_req_valid_o, 0);
    chk("flush_req_no_resp", ifill_resp_valid_o, 0);
    tick();
    #1;
    chk("flush_req_stays_idle", mem_req_valid_o, 0);

    // Flush after ready with 2 of 4 beats received
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h80_0000_3010;
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    chk("flush_fill_paddr", mem_req_paddr_o, 40'h80_0000_3000);
    tick();
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = {4{32'hE0E0_0001}};
    tick();
    mem_resp_data_i   = {4{32'hE0E0_0002}};
    flush_i           = 1'b1;
    ifill_req_valid_i = 1'b0;
    tick();
    flush_i         = 1'b0;
    inv_valid_i     = 1'b1;
    inv_paddr_i     = 40'h2000;
    mem_resp_data_i = {4{32'hE0E0_0003}};
    #1;
    chk("drain_no_req", mem_req_valid_o, 0);
    chk("drain_no_resp", ifill_resp_valid_o, 0);
    chk("drain_inv_ready", inv_ready_o, 0);
    tick();
    mem_resp_data_i = {4{32'hE0E0_0004}};
    #1;
    chk("drain_last_no_resp", ifill_resp_valid_o, 0);
    chk("drain_last_inv_ready", inv_ready_o, 0);
    tick();
    mem_resp_valid_i = 1'b0;
    #1;
    chk("drain_done_no_resp", ifill_resp_valid_o, 0);
    chk("drain_done_inv_ready", inv_ready_o, 1);
    tick();
    inv_valid_i = 1'b0;
    #1;
    chk("drain_inv_pulse", ifill_resp_inv_valid_o, 1);
    chk("drain_inv_paddr", ifill_resp_inv_paddr_o, 40'h2000);
    tick();
    #1;
    chk("drain_inv_pulse_end", ifill_resp_inv_valid_o, 0);

    // Fill after a drained flush
    beat_tbl[0] = {4{32'h5A5A_0010}};
    beat_tbl[1] = {4{32'h5A5A_0020}};
    beat_tbl[2] = {4{32'h5A5A_0030}};
    beat_tbl[3] = {4{32'h5A5A_0040}};
    run_fill(40'h80_0000_4000, 40'h80_0000_4000, 0, 0);

    // Simultaneous invalidation and miss: invalidation first
    inv_valid_i       = 1'b1;
    inv_paddr_i       = 40'h1000;
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h80_0000_5040;
    #1;
    chk("sim_inv_ready", inv_ready_o, 1);
    chk("sim_inv_pulse_not_yet", ifill_resp_inv_valid_o, 0);
    tick();
    inv_valid_i = 1'b0;
    #1;
    chk("sim_inv_pulse", ifill_resp_inv_valid_o, 1);
    chk("sim_inv_paddr", ifill_resp_inv_paddr_o, 40'h1000);
    chk("sim_req_not_yet", mem_req_valid_o, 0);
    tick();
    #1;
    chk("sim_inv_pulse_end", ifill_resp_inv_valid_o, 0);
    beat_tbl[0] = {4{32'h0101_0101}};
    beat_tbl[1] = {4{32'h0202_0202}};
    beat_tbl[2] = {4{32'h0303_0303}};
    beat_tbl[3] = {4{32'h0404_0404}};
    req_phase(40'h80_0000_5040, 0);
    fill_phase(0);

    // Invalidation held during a fill waits for IDLE
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h80_0000_6000;
    tick();
    req_phase(40'h80_0000_6000, 0);
    inv_valid_i = 1'b1;
    inv_paddr_i = 40'h3000;
    beat_tbl[0] = {4{32'h6666_0001}};
    beat_tbl[1] = {4{32'h6666_0002}};
    beat_tbl[2] = {4{32'h6666_0003}};
    beat_tbl[3] = {4{32'h6666_0004}};
    fill_phase(1);
    chk("held_inv_ready_idle", inv_ready_o, 1);
    tick();
    inv_valid_i = 1'b0;
    #1;
    chk("held_inv_pulse", ifill_resp_inv_valid_o, 1);
    chk("held_inv_paddr", ifill_resp_inv_paddr_o, 40'h3000);

    // Asynchronous reset mid-fill
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h80_0000_7000;
    tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = {4{32'h7777_0001}};
    tick();
    mem_resp_data_i = {4{32'h7777_0002}};
    tick();
    mem_resp_valid_i  = 1'b0;
    ifill_req_valid_i = 1'b0;
    #1;
    rstn_i = 1'b0;
    #1;
    chk("arst_mem_req_valid", mem_req_valid_o, 0);
    chk("arst_resp_valid", ifill_resp_valid_o, 0);
    chk("arst_resp_ack", ifill_resp_ack_o, 0);
    chk("arst_data", ifill_resp_data_o, 0);
    chk("arst_mem_paddr", mem_req_paddr_o, 0);
    chk("arst_inv_valid", ifill_resp_inv_valid_o, 0);
    chk("arst_inv_ready", inv_ready_o, 0);
    #1;
    rstn_i = 1'b1;
    tick();
    beat_tbl[0] = {4{32'h8888_0001}};
    beat_tbl[1] = {4{32'h8888_0002}};
    beat_tbl[2] = {4{32'h8888_0003}};
    beat_tbl[3] = {4{32'h8888_0004}};
    run_fill(40'h80_0000_80BF, 40'h80_0000_8080, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
